dmem_responder: RTL and testbench
=================================

# dmem_responder

Data-memory responder for the ONC-16 core: the slave end of the CPU's `dmem_*` interface. It serves the core's single-cycle loads combinationally and commits stores on the clock edge. It holds a word-addressed RAM and a small MMIO region: a buffered output port with a valid/ready handshake toward an external sink, a status register, and an optional free-running timer. It sits beside the core in the SoC top, wired directly to `dmem_addr`, `dmem_dout`, `dmem_we` and `dmem_din`.

## Interface
- `RAM_DEPTH`, 256: number of 16-bit RAM words; power of two, at most 0x8000.
- `FIFO_DEPTH`, 4: output FIFO entries; legal values are 2 and 4.
- `clock`  in  1: single clock; all state updates on the rising edge.
- `n_rst`  in  1: asynchronous, active-low reset.
- `dmem_addr`  in  16: word address from the core.
- `dmem_dout`  in  16: store data from the core.
- `dmem_we`  in  1: store strobe, one cycle per store.
- `dmem_din`  out  16: load data to the core; combinational from `dmem_addr`.
- `out_data`  out  16: FIFO head word.
- `out_valid`  out  1: FIFO non-empty.
- `out_ready`  in  1: sink accepts the head when high together with `out_valid`.

## Operation
- Address map:
  - RAM occupies 0x0000..RAM_DEPTH-1.
  - OUT_DATA is 0xFF00.
  - OUT_STAT is 0xFF01.
  - TIMER is 0xFF02 and exists only with the macro.
  - Every other address is unmapped.
- RAM:
  - Store writes `dmem_dout` at the edge.
  - Load returns the stored word combinationally, read-before-write within the cycle.
  - RAM contents are not reset.
- OUT_DATA store pushes `dmem_dout` into the FIFO. OUT_DATA load returns 0x0000.
- OUT_STAT load returns:
  - bit0 = empty
  - bit1 = full
  - bit2 = sticky overflow
  - bits[5:3] = occupancy
  - upper bits 0
- OUT_STAT store with `dmem_dout[2]`=1 clears overflow. All other bits of the store are ignored.
- Pop occurs when `out_valid && out_ready`. The head advances at the edge.
- Push while full:
  - Without a same-cycle pop, the push is dropped and overflow is set.
  - With a same-cycle pop, the push is accepted and occupancy is unchanged.
- Push and pop on a non-full, non-empty FIFO leaves occupancy unchanged.
- Unmapped addresses: stores are ignored and loads return 0x0000.
- Read/write pointers are `log2(FIFO_DEPTH)` bits and wrap modulo FIFO_DEPTH. Occupancy is `log2(FIFO_DEPTH)+1` bits.

## Timing
- Load latency is 0 cycles, combinational.
- Store takes effect at the next rising edge and is visible to loads in the following cycle.
- Push into an empty FIFO raises `out_valid` in the cycle after the store edge. `out_data` is valid in that same cycle.
- `out_data` and `out_valid` are driven from registered state only. There is no combinational path from `dmem_*` or from `out_ready`.
- `out_data` must stay stable while `out_valid && !out_ready`.
- Reset values:
  - `out_valid`=0 and `out_data`=0x0000.
  - Pointers, occupancy and overflow are 0; timer is 0.
  - `dmem_din` follows the address decode.
- Reset asserted mid-transfer empties the FIFO immediately and asynchronously. Pending entries are lost.

## Configuration
- `DMEM_TIMER_EN` defined:
  - TIMER at 0xFF02 is a 16-bit counter that increments every cycle out of reset and wraps 0xFFFF→0x0000.
  - Load returns the current value.
  - A store loads `dmem_dout`, and counting resumes from that value in the next cycle.
- `DMEM_TIMER_EN` undefined: 0xFF02 is unmapped and no counter flops exist.

## Structure
- Shared constants belong in `def.v`:
  - MMIO addresses `DMEM_OUT_DATA_ADDR`, `DMEM_OUT_STAT_ADDR`, `DMEM_TIMER_ADDR`.
  - OUT_STAT bit positions.
  - Data width reuses the existing `DATA_W`.
- Sub-module `out_fifo` holds storage, pointers, occupancy, the overflow flag and the valid/ready logic.
- The top level holds the address decode, RAM array, load mux and the optional timer.

## Test plan
- Reset, then store 0x1234→0x0010 and load 0x0010. The load must return 0x1234; address 0x0011 must read back unchanged.
- Push 0xAAAA and 0xBBBB with `out_ready`=0:
  - `out_valid`=1 and `out_data` holds 0xAAAA stable.
  - OUT_STAT reads 0x0010.
  - Raise `out_ready`: the sink sees 0xAAAA then 0xBBBB, after which `out_valid`=0 and OUT_STAT reads 0x0001.
- Push 5 words with `out_ready`=0 and FIFO_DEPTH=4:
  - OUT_STAT reads 0x0026 (full, overflow, count 4); the 5th word is absent.
  - Store 0x0004 to OUT_STAT and read back 0x0022.
- FIFO full with `out_ready`=1 plus a same-cycle push of 0x5555: occupancy stays 4 and 0x5555 emerges last.
- Store to 0x8000 and 0xFF10, then load both: each returns 0x0000 and RAM is unchanged.
- With `DMEM_TIMER_EN`: store 0xFFFE to TIMER. Loads on the next three cycles return 0xFFFE, 0xFFFF, 0x0000. Assert `n_rst` mid-count and the timer reads 0x0000.

Source files
------------

// File: rtl/dmem_responder_pkg.sv
// Shared constants for dmem_responder: data width, MMIO map, OUT_STAT layout and decode selects.
// The optional timer is enabled with the DMEM_TIMER_EN macro.
package dmem_responder_pkg;

    localparam int unsigned DATA_W = 16;

    localparam logic [DATA_W-1:0] DMEM_OUT_DATA_ADDR = 16'hFF00;
    localparam logic [DATA_W-1:0] DMEM_OUT_STAT_ADDR = 16'hFF01;
    localparam logic [DATA_W-1:0] DMEM_TIMER_ADDR    = 16'hFF02;

    localparam int unsigned STAT_EMPTY_BIT = 0;
    localparam int unsigned STAT_FULL_BIT  = 1;
    localparam int unsigned STAT_OVF_BIT   = 2;
    localparam int unsigned STAT_CNT_LSB   = 3;
    localparam int unsigned STAT_CNT_W     = 3;

    typedef enum logic [2:0] {
        SelNone,
        SelRam,
        SelOutData,
        SelOutStat,
        SelTimer
    } dmem_sel_e;

    function automatic logic [DATA_W-1:0] pack_stat(input logic empty, input logic full,
                                                    input logic ovf,
                                                    input logic [STAT_CNT_W-1:0] cnt);
        logic [DATA_W-1:0] s;
        s = '0;
        s[STAT_EMPTY_BIT] = empty;
        s[STAT_FULL_BIT]  = full;
        s[STAT_OVF_BIT]   = ovf;
        s[STAT_CNT_LSB +: STAT_CNT_W] = cnt;
        return s;
    endfunction

endpackage

// File: rtl/dmem_responder_out_fifo.sv
// Output FIFO toward the external sink: storage, pointers, occupancy, sticky overflow and
// the valid/ready handshake. Outputs come from registered state only.
module dmem_responder_out_fifo
    import dmem_responder_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                  clock,
    input  logic                  n_rst,
    input  logic                  push_i,
    input  logic [DATA_W-1:0]     push_data_i,
    input  logic                  clr_ovf_i,
    input  logic                  out_ready_i,
    output logic [DATA_W-1:0]     out_data_o,
    output logic                  out_valid_o,
    output logic                  empty_o,
    output logic                  full_o,
    output logic                  ovf_o,
    output logic [STAT_CNT_W-1:0] count_o
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic              ovf_q, ovf_d;
    logic              full, pop, accept;

    always_comb begin
        full   = (count_q == CW'(DEPTH));
        pop    = (count_q != '0) && out_ready_i;
        // A full FIFO still accepts a push when the head leaves in the same cycle.
        accept = push_i && (!full || pop);

        wr_ptr_d = wr_ptr_q + PW'(accept);
        rd_ptr_d = rd_ptr_q + PW'(pop);
        count_d  = count_q + CW'(accept) - CW'(pop);
        ovf_d    = (ovf_q && !clr_ovf_i) || (push_i && full && !pop);
    end

    always_ff @(posedge clock or negedge n_rst) begin
        if (!n_rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
        end
    end

    always_ff @(posedge clock) begin
        if (accept) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    // Storage is not reset, so gate the head word to present zero while empty.
    assign out_valid_o = (count_q != '0);
    assign out_data_o  = out_valid_o ? mem_q[rd_ptr_q] : '0;
    assign empty_o     = (count_q == '0);
    assign full_o      = full;
    assign ovf_o       = ovf_q;
    assign count_o     = STAT_CNT_W'(count_q);

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: RAM, MMIO decode, combinational load mux and the output FIFO.
// Define DMEM_TIMER_EN to add the free-running timer at DMEM_TIMER_ADDR.
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int unsigned RAM_DEPTH  = 256,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic              clock,
    input  logic              n_rst,
    input  logic [DATA_W-1:0] dmem_addr,
    input  logic [DATA_W-1:0] dmem_dout,
    input  logic              dmem_we,
    output logic [DATA_W-1:0] dmem_din,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready
);

    localparam int unsigned AW = $clog2(RAM_DEPTH);
`ifdef DMEM_TIMER_EN
    localparam bit TimerEn = 1'b1;
`else
    localparam bit TimerEn = 1'b0;
`endif

    dmem_sel_e         sel;
    logic [AW-1:0]     ram_idx;
    logic              ram_we, push, clr_ovf;
    logic [DATA_W-1:0] ram_q [RAM_DEPTH];
    logic              fifo_empty, fifo_full, fifo_ovf;
    logic [STAT_CNT_W-1:0] fifo_count;

    always_comb begin
        sel = SelNone;
        if (dmem_addr[DATA_W-1:AW] == '0) begin
            sel = SelRam;
        end else if (dmem_addr == DMEM_OUT_DATA_ADDR) begin
            sel = SelOutData;
        end else if (dmem_addr == DMEM_OUT_STAT_ADDR) begin
            sel = SelOutStat;
        end else if (TimerEn && (dmem_addr == DMEM_TIMER_ADDR)) begin
            sel = SelTimer;
        end
    end

    assign ram_idx = dmem_addr[AW-1:0];
    assign ram_we  = dmem_we && (sel == SelRam);
    assign push    = dmem_we && (sel == SelOutData);
    assign clr_ovf = dmem_we && (sel == SelOutStat) && dmem_dout[STAT_OVF_BIT];

    always_ff @(posedge clock) begin
        if (ram_we) begin
            ram_q[ram_idx] <= dmem_dout;
        end
    end

`ifdef DMEM_TIMER_EN
    logic [DATA_W-1:0] timer_q, timer_d;

    always_comb begin
        timer_d = timer_q + 16'd1;
        if (dmem_we && (sel == SelTimer)) begin
            timer_d = dmem_dout;
        end
    end

    always_ff @(posedge clock or negedge n_rst) begin
        if (!n_rst) begin
            timer_q <= '0;
        end else begin
            timer_q <= timer_d;
        end
    end
`endif

    always_comb begin
        dmem_din = '0;
        case (sel)
            SelRam:     dmem_din = ram_q[ram_idx];
            SelOutStat: dmem_din = pack_stat(fifo_empty, fifo_full, fifo_ovf, fifo_count);
`ifdef DMEM_TIMER_EN
            SelTimer:   dmem_din = timer_q;
`endif
            default:    dmem_din = '0;
        endcase
    end

    dmem_responder_out_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_out_fifo (
        .clock       (clock),
        .n_rst       (n_rst),
        .push_i      (push),
        .push_data_i (dmem_dout),
        .clr_ovf_i   (clr_ovf),
        .out_ready_i (out_ready),
        .out_data_o  (out_data),
        .out_valid_o (out_valid),
        .empty_o     (fifo_empty),
        .full_o      (fifo_full),
        .ovf_o       (fifo_ovf),
        .count_o     (fifo_count)
    );

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: directed loads/stores checked inline, FIFO output checked by a
// scoreboard monitor against a queue of expected words.
module tb_dmem_responder;

    logic        clock;
    logic        n_rst;
    logic [15:0] dmem_addr;
    logic [15:0] dmem_dout;
    logic        dmem_we;
    logic [15:0] dmem_din;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_ready;

    int total = 0;
    int bad   = 0;
    logic [15:0] exp_q[$];

    dmem_responder #(
        .RAM_DEPTH  (256),
        .FIFO_DEPTH (4)
    ) dut (
        .clock     (clock),
        .n_rst     (n_rst),
        .dmem_addr (dmem_addr),
        .dmem_dout (dmem_dout),
        .dmem_we   (dmem_we),
        .dmem_din  (dmem_din),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic ld_chk(input string name, input logic [15:0] addr, input logic [15:0] exp);
        dmem_addr = addr;
        #1;
        chk(name, dmem_din, exp);
    endtask

    task automatic store(input logic [15:0] addr, input logic [15:0] data);
        dmem_addr = addr;
        dmem_dout = data;
        dmem_we   = 1'b1;
        @(posedge clock);
        #1;
        dmem_we   = 1'b0;
    endtask

    task automatic push(input logic [15:0] data, input bit accepted);
        if (accepted) exp_q.push_back(data);
        store(16'hFF00, data);
    endtask

    task automatic drain(input string name);
        out_ready = 1'b1;
        for (int i = 0; i < 30; i++) begin
            @(posedge clock);
            #1;
            if (exp_q.size() == 0) break;
        end
        out_ready = 1'b0;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL %s drain timeout: left %0d want 0", name, exp_q.size());
            exp_q.delete();
        end
        chk({name, " valid after drain"}, {15'd0, out_valid}, 16'h0000);
    endtask

    // Scoreboard: whenever the head is valid it must match the oldest expected word.
    always @(negedge clock) begin
        if (n_rst && out_valid) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL out_data unexpected: got %h want none", out_data);
            end else begin
                chk("out_data", out_data, exp_q[0]);
                if (out_ready) void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        n_rst     = 1'b0;
        dmem_addr = 16'hFF01;
        dmem_dout = 16'h0000;
        dmem_we   = 1'b0;
        out_ready = 1'b0;
        #2;
        chk("reset valid", {15'd0, out_valid}, 16'h0000);
        chk("reset data", out_data, 16'h0000);
        ld_chk("reset stat", 16'hFF01, 16'h0001);
        repeat (2) @(posedge clock);
        #1;
        n_rst = 1'b1;
        @(posedge clock);
        #1;

        // RAM store/load and neighbour integrity
        store(16'h0011, 16'hBEEF);
        store(16'h0010, 16'h1234);
        ld_chk("ram 0x10", 16'h0010, 16'h1234);
        ld_chk("ram 0x11", 16'h0011, 16'hBEEF);
        store(16'h00FF, 16'h7E7E);
        ld_chk("ram top", 16'h00FF, 16'h7E7E);

        // Read-before-write within the store cycle
        store(16'h0020, 16'h1111);
        dmem_addr = 16'h0020;
        dmem_dout = 16'h2222;
        dmem_we   = 1'b1;
        #1;
        chk("rbw old", dmem_din, 16'h1111);
        @(posedge clock);
        #1;
        dmem_we = 1'b0;
        ld_chk("rbw new", 16'h0020, 16'h2222);

        // Two pushes with sink stalled, then drain
        push(16'hAAAA, 1'b1);
        chk("valid after 1 push", {15'd0, out_valid}, 16'h0001);
        chk("data after 1 push", out_data, 16'hAAAA);
        push(16'hBBBB, 1'b1);
        repeat (3) @(posedge clock);
        #1;
        chk("head stable", out_data, 16'hAAAA);
        ld_chk("stat 2", 16'hFF01, 16'h0010);
        ld_chk("out_data load", 16'hFF00, 16'h0000);
        drain("two");
        ld_chk("stat empty", 16'hFF01, 16'h0001);

        // Overflow: five pushes into depth four
        for (int i = 0; i < 5; i++) push(16'h1001 + 16'(i), (i < 4));
        ld_chk("stat ovf", 16'hFF01, 16'h0026);
        store(16'hFF01, 16'h0004);
        ld_chk("stat ovf clr", 16'hFF01, 16'h0022);

        // Full with same-cycle pop and push
        out_ready = 1'b1;
        push(16'h5555, 1'b1);
        out_ready = 1'b0;
        ld_chk("stat full push pop", 16'hFF01, 16'h0022);
        drain("full pp");
        ld_chk("stat after pp", 16'hFF01, 16'h0001);

        // Unmapped stores and loads
        store(16'h0000, 16'h0F0F);
        store(16'h8000, 16'hDEAD);
        store(16'hFF10, 16'hDEAD);
        ld_chk("unmapped 8000", 16'h8000, 16'h0000);
        ld_chk("unmapped FF10", 16'hFF10, 16'h0000);
        ld_chk("ram 0 intact", 16'h0000, 16'h0F0F);
        ld_chk("ram 0x10 intact", 16'h0010, 16'h1234);

`ifdef DMEM_TIMER_EN
        store(16'hFF02, 16'hFFFE);
        ld_chk("timer 0", 16'hFF02, 16'hFFFE);
        @(posedge clock);
        #1;
        ld_chk("timer 1", 16'hFF02, 16'hFFFF);
        @(posedge clock);
        #1;
        ld_chk("timer 2", 16'hFF02, 16'h0000);
        repeat (3) @(posedge clock);
        #1;
        n_rst = 1'b0;
        ld_chk("timer reset", 16'hFF02, 16'h0000);
        @(posedge clock);
        #1;
        n_rst = 1'b1;
`else
        store(16'hFF02, 16'h1234);
        ld_chk("no timer", 16'hFF02, 16'h0000);
`endif

        // Asynchronous reset with pending entries
        push(16'hC0DE, 1'b1);
        push(16'hCAFE, 1'b1);
        #2;
        n_rst = 1'b0;
        exp_q.delete();
        #1;
        chk("rst mid valid", {15'd0, out_valid}, 16'h0000);
        chk("rst mid data", out_data, 16'h0000);
        ld_chk("rst mid stat", 16'hFF01, 16'h0001);
        @(posedge clock);
        #1;
        n_rst = 1'b1;
        @(posedge clock);
        #1;
        chk("post rst valid", {15'd0, out_valid}, 16'h0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
